truth_table_checker: RTL and testbench

Response-side companion to the 4-input stimulus sweep that drives `circuit1Struct` / `circuit1DataFlow`. It observes the applied vector `{w,x,y,z}` and the unit output `f`, then synchronizes and debounces each newly applied vector. Once the vector is stable it records `f` into a 16-entry truth table. After all 16 vectors have been captured it compares the table against a parameterized expected function and reports pass/fail plus a per-vector mismatch mask. It sits beside the unit under test, in simulation or on board, and closes the loop the stimulus sweep opens.

---
 rtl/truth_table_checker_pkg.sv | 18 +
 rtl/truth_table_checker_sync2.sv | 34 +++
 rtl/truth_table_checker.sv | 172 +++++++++++++++++
 tb/tb_truth_table_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Purpose : shared constants and state encoding for the truth-table checker.
// Latency : n/a (package only).
// Backpressure: n/a; the checker only observes and never stalls its sources.
package tt_check_pkg;

   localparam int N_VEC = 16;
   localparam int VEC_W = 4;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [N_VEC-1:0] ALL_SEEN = 16'hFFFF;

endpackage

// File: rtl/truth_table_checker_sync2.sv
// Purpose : W-bit two-flop synchronizer for asynchronous pins.
// Latency : 2 clocks from pin to o_q.
// Backpressure: none; the pins are sampled every cycle.
//
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears both stages
//   i_d  - asynchronous inputs
//   o_q  - synchronized outputs
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/truth_table_checker.sv
// Purpose : debounce each applied {w,x,y,z} vector, record f into a 16-entry
//           table, then compare the full table against EXPECTED_TT.
// Latency : pin change to sample pulse is 2 + SETTLE_CYCLES + 1 clocks.
// Backpressure: none; vectors arriving after the table is full are ignored.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   clear           - synchronous restart of the capture (priority over all)
//   w,x,y,z         - applied vector (w is MSB), asynchronous
//   f               - unit-under-test output, asynchronous
//   sample          - one-cycle pulse when a table entry is written
//   captured, seen  - recorded f per index, and which indices were captured
//   done, pass      - table complete, table complete and equal to EXPECTED_TT
//   mismatch        - per-index difference against EXPECTED_TT once done
module truth_table_checker
   import tt_check_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED_TT   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        w,
   input  logic        x,
   input  logic        y,
   input  logic        z,
   input  logic        f,
   output logic        sample,
   output logic [15:0] captured,
   output logic [15:0] seen,
   output logic        done,
   output logic        pass,
   output logic [15:0] mismatch
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [4:0]       w_sync;
   logic [VEC_W-1:0] w_vs;
   logic             w_fs;

   state_t           r_state;
   state_t           w_next_state;
   logic [VEC_W-1:0] r_vec_q;
   logic [3:0]       r_cnt;
   logic [N_VEC-1:0] r_captured;
   logic [N_VEC-1:0] r_seen;
   logic             r_done;
   logic             r_pass;
   logic [N_VEC-1:0] r_mismatch;

   logic             w_vec_changed;
   logic             w_load;
   logic             w_capture;
   logic [N_VEC-1:0] w_onehot;
   logic [N_VEC-1:0] w_cap_nxt;
   logic [N_VEC-1:0] w_seen_nxt;

   sync2 #(.W(5)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d ({w, x, y, z, f}),
      .o_q (w_sync)
   );

   assign w_vs = w_sync[4:1];
   assign w_fs = w_sync[0];

   assign w_vec_changed = (w_vs != r_vec_q);
   assign w_onehot      = {{(N_VEC-1){1'b0}}, 1'b1} << r_vec_q;
   assign w_cap_nxt     = (r_captured & ~w_onehot) | (w_fs ? w_onehot : '0);
   assign w_seen_nxt    = r_seen | w_onehot;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; clear overrides every state
   always_comb begin
      w_next_state = r_state;
      if (clear) begin
         w_next_state = SETTLE;
      end else begin
         case (r_state)
            SETTLE: begin
               if (!w_vec_changed && (r_cnt == SETTLE_LAST)) begin
                  w_next_state = CAPTURE;
               end
            end
            CAPTURE: begin
               w_next_state = (w_seen_nxt == ALL_SEEN) ? DONE : HOLD;
            end
            HOLD: begin
               if (w_vec_changed) begin
                  w_next_state = SETTLE;
               end
            end
            DONE:    w_next_state = DONE;
            default: w_next_state = SETTLE;
         endcase
      end
   end

   // Output / control decode
   always_comb begin
      w_capture = 1'b0;
      w_load    = 1'b0;
      if (clear) begin
         // restart tracks whatever vector is present now, so it gets captured
         w_load = 1'b1;
      end else begin
         case (r_state)
            SETTLE:  w_load    = w_vec_changed;
            CAPTURE: w_capture = 1'b1;
            HOLD:    w_load    = w_vec_changed;
            default: w_load    = 1'b0;
         endcase
      end
   end

   // Vector tracker and stable-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec_q <= '0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_vec_q <= w_vs;
         r_cnt   <= '0;
      end else if (r_state == SETTLE) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // Table and verdict registers; verdict is computed from the post-write table
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_captured <= '0;
         r_seen     <= '0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mismatch <= '0;
      end else if (clear) begin
         r_captured <= '0;
         r_seen     <= '0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mismatch <= '0;
      end else if (w_capture) begin
         r_captured <= w_cap_nxt;
         r_seen     <= w_seen_nxt;
         if (w_seen_nxt == ALL_SEEN) begin
            r_done     <= 1'b1;
            r_pass     <= (w_cap_nxt == EXPECTED_TT);
            r_mismatch <= w_cap_nxt ^ EXPECTED_TT;
         end
      end
   end

   assign sample   = w_capture;
   assign captured = r_captured;
   assign seen     = r_seen;
   assign done     = r_done;
   assign pass     = r_pass;
   assign mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_checker.sv
// Purpose : directed bench for truth_table_checker with a table-level model.
// Latency : n/a.
// Backpressure: n/a.
module tb_truth_table_checker;

   localparam logic [15:0] EXP = 16'hA5C3;
   localparam int          SC  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        w, x, y, z, f;
   logic        sample;
   logic [15:0] captured;
   logic [15:0] seen;
   logic        done;
   logic        pass;
   logic [15:0] mismatch;

   truth_table_checker #(.SETTLE_CYCLES(SC), .EXPECTED_TT(EXP)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .w        (w),
      .x        (x),
      .y        (y),
      .z        (z),
      .f        (f),
      .sample   (sample),
      .captured (captured),
      .seen     (seen),
      .done     (done),
      .pass     (pass),
      .mismatch (mismatch)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: what the table must hold, derived from which vectors were held long enough
   logic [15:0] exp_tt;
   logic [15:0] m_cap;
   logic [15:0] m_seen;
   logic        m_done;
   logic [3:0]  m_last;
   logic        m_fresh;
   logic        m_valid;
   int          m_samples;
   int          dut_samples;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %04h expected %04h", name, act, exp_v);
   endtask

   // Sample-pulse counter plus per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (sample === 1'b1) dut_samples++;
      if (m_valid) begin
         chk("captured", captured, m_cap);
         chk("seen", seen, m_seen);
         chk("done", {15'd0, done}, {15'd0, m_done});
         chk("pass", {15'd0, pass}, {15'd0, m_done && (m_cap == exp_tt)});
         chk("mismatch", mismatch, m_done ? (m_cap ^ exp_tt) : 16'h0000);
         chk("sample_idle", {15'd0, sample}, 16'h0000);
         chk("sample_count", 16'(dut_samples), 16'(m_samples));
      end
   end

   task automatic model_clear();
      m_cap   = '0;
      m_seen  = '0;
      m_done  = 1'b0;
      m_last  = 4'd0;
      m_fresh = 1'b1;
   endtask

   // Asserts reset mid-cycle, checks outputs clear immediately, parks pins at 0000
   task automatic do_reset();
      @(negedge clk);
      m_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_captured", captured, 16'h0000);
      chk("rst_seen", seen, 16'h0000);
      chk("rst_mismatch", mismatch, 16'h0000);
      chk("rst_flags", {13'd0, sample, done, pass}, 16'h0000);
      {w, x, y, z} = 4'd0;
      f = exp_tt[0];
      clear = 1'b0;
      model_clear();
      m_samples   = 0;
      dut_samples = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Hold vector v with f = fv for 'hold' clocks. A hold of 8 covers the full
   // pin-to-table path; a hold of 2 is too short to survive settling.
   task automatic apply_vec(input logic [3:0] v, input logic fv, input int hold);
      logic cap;
      @(negedge clk);
      m_valid = 1'b0;
      {w, x, y, z} = v;
      f = fv;
      cap = (hold >= SC + 3) && ((v != m_last) || m_fresh) && !m_done;
      m_last  = v;
      m_fresh = 1'b0;
      if (hold >= 6) begin
         repeat (6) @(posedge clk);
         if (cap) begin
            m_cap[v]  = fv;
            m_seen[v] = 1'b1;
            m_samples++;
            m_done = (m_seen == 16'hFFFF);
         end
         m_valid = 1'b1;
         repeat (hold - 6) @(posedge clk);
      end else begin
         repeat (hold) @(posedge clk);
      end
   endtask

   task automatic sweep(input logic [15:0] flip, input int short_idx);
      for (int v = 0; v < 16; v++) begin
         apply_vec(4'(v), exp_tt[v] ^ flip[v], (v == short_idx) ? 2 : 8);
      end
   endtask

   initial begin
      exp_tt  = EXP;
      m_valid = 1'b0;
      rst     = 1'b1;
      clear   = 1'b0;
      {w, x, y, z} = 4'd0;
      f = exp_tt[0];

      // Clean sweep
      do_reset();
      sweep(16'h0000, 16);
      chk("t1_captured", captured, 16'hA5C3);
      chk("t1_flags", {14'd0, done, pass}, 16'h0003);
      chk("t1_mismatch", mismatch, 16'h0000);
      chk("t1_samples", 16'(dut_samples), 16'd16);

      // f wrong at vector 0110
      do_reset();
      sweep(16'h0040, 16);
      chk("t2_captured", captured, 16'hA583);
      chk("t2_mismatch", mismatch, 16'h0040);
      chk("t2_flags", {14'd0, done, pass}, 16'h0002);

      // 0101 too short, then reapplied
      do_reset();
      sweep(16'h0000, 5);
      chk("t3_seen", seen, 16'hFFDF);
      chk("t3_done", {15'd0, done}, 16'h0000);
      apply_vec(4'd5, exp_tt[5], 8);
      chk("t3_seen_full", seen, 16'hFFFF);
      chk("t3_flags", {14'd0, done, pass}, 16'h0003);

      // Revisit 0011 with f flipped before the sweep finishes
      do_reset();
      for (int v = 0; v < 8; v++) apply_vec(4'(v), exp_tt[v], 8);
      apply_vec(4'd3, ~exp_tt[3], 8);
      chk("t4_cap3", {15'd0, captured[3]}, {15'd0, ~exp_tt[3]});
      chk("t4_samples", 16'(dut_samples), 16'd9);
      chk("t4_done_early", {15'd0, done}, 16'h0000);
      for (int v = 8; v < 16; v++) apply_vec(4'(v), exp_tt[v], 8);
      chk("t4_captured", captured, 16'hA5CB);
      chk("t4_flags", {14'd0, done, pass}, 16'h0002);
      chk("t4_samples_end", 16'(dut_samples), 16'd17);

      // Reset after 8 vectors, then a full resumed sweep
      do_reset();
      for (int v = 0; v < 8; v++) apply_vec(4'(v), exp_tt[v], 8);
      chk("t5_seen_half", seen, 16'h00FF);
      do_reset();
      sweep(16'h0000, 16);
      chk("t5_flags", {14'd0, done, pass}, 16'h0003);

      // Vectors after done are ignored; clear restarts the capture
      apply_vec(4'd3, ~exp_tt[3], 8);
      apply_vec(4'd9, ~exp_tt[9], 8);
      apply_vec(4'd0, exp_tt[0], 8);
      chk("t6_no_sample", 16'(dut_samples), 16'd16);
      chk("t6_frozen", captured, 16'hA5C3);
      @(negedge clk);
      m_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_clr_captured", captured, 16'h0000);
      chk("t6_clr_seen", seen, 16'h0000);
      chk("t6_clr_flags", {14'd0, done, pass}, 16'h0000);
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      sweep(16'h0000, 16);
      chk("t6_captured", captured, 16'hA5C3);
      chk("t6_flags", {14'd0, done, pass}, 16'h0003);
      chk("t6_samples", 16'(dut_samples), 16'd32);

      @(negedge clk);
      m_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
